// File: rtl/sweep_stim_gen.sv
// sweep_stim_gen: stepped-sweep stimulus source with a valid/ready handshake.
// Emits START_VAL, START_VAL+STEP, ... up to the last value <= LIMIT, with an
// optional DWELL idle gap after each accepted value.
// Optional build macro: SWEEP_STIM_REPEAT_EN (sweep restarts after each done pulse).
// All outputs are decoded from registered state only; no input-to-output paths.
module sweep_stim_gen #(
    parameter int WIDTH     = 8,
    parameter int START_VAL = 0,
    parameter int STEP      = 10,
    parameter int LIMIT     = 100,
    parameter int DWELL     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ready,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [7:0]       count
);

    // Dwell counter only ever holds DWELL-1 down to 0.
    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    // One extra bit on the step/limit compare so the sweep can reach the
    // top code without the next value wrapping back below LIMIT.
    localparam logic [WIDTH:0]   STEP_X   = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   LIMIT_X  = (WIDTH+1)'(LIMIT);
    localparam logic [WIDTH-1:0] START_X  = WIDTH'(START_VAL);
    localparam logic [DW_W-1:0]  DWELL_LD = DW_W'((DWELL > 0) ? DWELL - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  data_q,  data_d;
    logic [7:0]        count_q, count_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [WIDTH:0]    next_val;

    assign next_val = {1'b0, data_q} + STEP_X;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= START_X;
            count_q <= 8'd0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            dwell_q <= dwell_d;
        end
    end

    // Next-state, next-data and output decode.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        dwell_d = dwell_q;
        valid   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    data_d  = START_X;
                    count_d = 8'd0;
                end
            end

            S_RUN: begin
                valid = 1'b1;
                busy  = 1'b1;
                if (ready) begin
                    count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    if (next_val > LIMIT_X) begin
                        // Hold the last transferred value through DONE.
                        state_d = S_DONE;
                    end else begin
                        data_d = next_val[WIDTH-1:0];
                        if (DWELL != 0) begin
                            state_d = S_GAP;
                            dwell_d = DWELL_LD;
                        end
                    end
                end
            end

            S_GAP: begin
                busy = 1'b1;
                if (dwell_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    dwell_d = dwell_q - DW_W'(1);
                end
            end

            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
`ifdef SWEEP_STIM_REPEAT_EN
                state_d = S_RUN;
                data_d  = START_X;
                count_d = 8'd0;
`else
                state_d = S_IDLE;
`endif
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data_out = data_q;
    assign count    = count_q;

endmodule

// File: tb/tb_sweep_stim_gen.sv
// Bench for sweep_stim_gen: several parameterisations driven with fixed and
// randomised ready patterns, checked against a value-list model of the sweep.
`timescale 1ns/1ps
module tb_sweep_stim_gen;

    localparam int NU = 5;

    // Per-instance parameters; the model derives everything from these.
    int p_start [NU] = '{0,   0,   0,   7,   0};
    int p_step  [NU] = '{10,  10,  16,  9,   1};
    int p_limit [NU] = '{100, 100, 255, 200, 255};
    int p_dwell [NU] = '{0,   2,   0,   1,   0};

    logic       clk = 1'b0;
    logic       rst   [NU];
    logic       start [NU];
    logic       ready [NU];
    logic       valid [NU];
    logic       busy  [NU];
    logic       done  [NU];
    logic [7:0] data_out [NU];
    logic [7:0] count    [NU];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sweep_stim_gen #(.WIDTH(8), .START_VAL(0), .STEP(10), .LIMIT(100), .DWELL(0)) u0 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .ready(ready[0]), .data_out(data_out[0]),
        .valid(valid[0]), .busy(busy[0]), .done(done[0]), .count(count[0]));
    sweep_stim_gen #(.WIDTH(8), .START_VAL(0), .STEP(10), .LIMIT(100), .DWELL(2)) u1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .ready(ready[1]), .data_out(data_out[1]),
        .valid(valid[1]), .busy(busy[1]), .done(done[1]), .count(count[1]));
    sweep_stim_gen #(.WIDTH(8), .START_VAL(0), .STEP(16), .LIMIT(255), .DWELL(0)) u2 (
        .clk(clk), .rst(rst[2]), .start(start[2]), .ready(ready[2]), .data_out(data_out[2]),
        .valid(valid[2]), .busy(busy[2]), .done(done[2]), .count(count[2]));
    sweep_stim_gen #(.WIDTH(8), .START_VAL(7), .STEP(9), .LIMIT(200), .DWELL(1)) u3 (
        .clk(clk), .rst(rst[3]), .start(start[3]), .ready(ready[3]), .data_out(data_out[3]),
        .valid(valid[3]), .busy(busy[3]), .done(done[3]), .count(count[3]));
    sweep_stim_gen #(.WIDTH(8), .START_VAL(0), .STEP(1), .LIMIT(255), .DWELL(0)) u4 (
        .clk(clk), .rst(rst[4]), .start(start[4]), .ready(ready[4]), .data_out(data_out[4]),
        .valid(valid[4]), .busy(busy[4]), .done(done[4]), .count(count[4]));

    // Packed snapshot {valid, busy, done, count, data_out} of one instance.
    function automatic logic [18:0] obs(input int u);
        return {valid[u], busy[u], done[u], count[u], data_out[u]};
    endfunction

    function automatic logic [18:0] expv(input bit v, input bit b, input bit d,
                                         input int c, input int dat);
        int cs;
        cs = (c > 255) ? 255 : c;
        return {v, b, d, 8'(cs), 8'(dat)};
    endfunction

    // Run one complete sweep on instance u.
    // mode 0: ready high; 1: random ready; 2: ready low 3 cycles while 30 is offered.
    task automatic run_sweep(input int u, input int mode, input bit hold_start, input string tag);
        int          vals[$];
        int          n;
        int          hold;
        bit          r;
        logic [18:0] got, want;
        vals = {};
        for (int v = p_start[u]; v <= p_limit[u]; v += p_step[u]) vals.push_back(v);
        n = vals.size();

        @(negedge clk);
        start[u] = 1'b1;
        ready[u] = (mode == 0);
        @(negedge clk);
        if (!hold_start) start[u] = 1'b0;

        for (int i = 0; i < n; i++) begin
            hold = 0;
            r    = 1'b0;
            while (!r) begin
                got  = obs(u);
                want = expv(1'b1, 1'b1, 1'b0, i, vals[i]);
                n_vec++;
                if (got !== want) begin
                    n_err++;
                    $display("FAIL %s u%0d offer[%0d] got %h want %h", tag, u, i, got, want);
                end
                case (mode)
                    0:       r = 1'b1;
                    1:       r = ($urandom_range(0, 9) < 6) || (hold >= 40);
                    default: r = !(vals[i] == 30 && hold < 3);
                endcase
                ready[u] = r;
                hold++;
                @(negedge clk);
            end
            if (i < n - 1) begin
                for (int d = 0; d < p_dwell[u]; d++) begin
                    got  = obs(u);
                    want = expv(1'b0, 1'b1, 1'b0, i + 1, vals[i+1]);
                    n_vec++;
                    if (got !== want) begin
                        n_err++;
                        $display("FAIL %s u%0d gap[%0d.%0d] got %h want %h", tag, u, i, d, got, want);
                    end
                    ready[u] = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            end
        end

        got  = obs(u);
        want = expv(1'b0, 1'b1, 1'b1, n, vals[n-1]);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s u%0d done got %h want %h", tag, u, got, want);
        end
        start[u] = 1'b0;
        ready[u] = 1'($urandom_range(0, 1));
        @(negedge clk);
`ifdef SWEEP_STIM_REPEAT_EN
        got  = obs(u);
        want = expv(1'b1, 1'b1, 1'b0, 0, p_start[u]);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s u%0d repeat got %h want %h", tag, u, got, want);
        end
        rst[u] = 1'b1;
        @(negedge clk);
        rst[u] = 1'b0;
`else
        for (int k = 0; k < 2; k++) begin
            got  = obs(u);
            want = expv(1'b0, 1'b0, 1'b0, n, vals[n-1]);
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL %s u%0d idle[%0d] got %h want %h", tag, u, k, got, want);
            end
            @(negedge clk);
        end
`endif
    endtask

    task automatic test_reset();
        logic [18:0] got, want;
        for (int u = 0; u < NU; u++) begin
            rst[u] = 1'b1; start[u] = 1'b0; ready[u] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < NU; u++) rst[u] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int u = 0; u < NU; u++) begin
                got  = obs(u);
                want = expv(1'b0, 1'b0, 1'b0, 0, p_start[u]);
                n_vec++;
                if (got !== want) begin
                    n_err++;
                    $display("FAIL reset u%0d cyc%0d got %h want %h", u, k, got, want);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        run_sweep(0, 0, 1'b0, "basic");
    endtask

    task automatic test_backpressure();
        run_sweep(0, 2, 1'b0, "bp");
    endtask

    task automatic test_dwell();
        run_sweep(1, 0, 1'b0, "dwell");
        run_sweep(1, 1, 1'b0, "dwell_rnd");
    endtask

    task automatic test_full_range();
        run_sweep(2, 0, 1'b0, "range16");
        run_sweep(4, 1, 1'b0, "range1");
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            run_sweep(3, 1, 1'b0, "rnd3");
            run_sweep(0, 1, 1'b0, "rnd0");
        end
    endtask

    task automatic test_reset_midsweep();
        logic [18:0] got, want;
        bit          hit;
        hit = 1'b0;
        @(negedge clk);
        start[0] = 1'b1;
        ready[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (valid[0] === 1'b1 && data_out[0] === 8'd50) hit = 1'b1;
            else @(negedge clk);
        end
        n_vec++;
        if (!hit) begin
            n_err++;
            $display("FAIL midrst_reach got data %0d want 50 within 20 cycles", data_out[0]);
        end
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            got  = obs(0);
            want = expv(1'b0, 1'b0, 1'b0, 0, 0);
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL midrst cyc%0d got %h want %h", k, got, want);
            end
            @(negedge clk);
        end
        run_sweep(0, 0, 1'b0, "after_rst");
    endtask

    task automatic test_start_held();
        run_sweep(0, 0, 1'b1, "held0");
        run_sweep(1, 1, 1'b1, "held1");
    endtask

    task automatic test_back_to_back();
        run_sweep(2, 1, 1'b0, "b2b_a");
        run_sweep(2, 0, 1'b0, "b2b_b");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_dwell();
        test_full_range();
        test_random();
        test_reset_midsweep();
        test_start_held();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
